// File: rtl/sw_score_controller_pkg.sv
// sw_pkg: shared FSM state, nucleotide codes and score-bias helper for the SW controller
package sw_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} sw_state_e;

    localparam logic [1:0] _T = 2'b00;
    localparam logic [1:0] _C = 2'b01;
    localparam logic [1:0] _A = 2'b10;
    localparam logic [1:0] _G = 2'b11;

    function automatic int zero_bias(input int sw);
        return 1 << (sw - 1);
    endfunction

endpackage

// File: rtl/sw_score_controller_if.sv
// sw_score_controller_if: host job/base/result handshakes plus scoring-array lines
// SW_CTRL_CYCLE_COUNT_EN adds res_cycles to the bundle.
interface sw_score_controller_if #(
    parameter int SCORE_WIDTH = 12,
    parameter int LOG_LENGTH  = 8,
    parameter int TLEN_WIDTH  = 16
);
    logic                   start_valid;
    logic                   start_ready;
    logic [LOG_LENGTH-1:0]  start_qlen;
    logic [TLEN_WIDTH-1:0]  start_tlen;
    logic                   abort;
    logic                   base_valid;
    logic                   base_ready;
    logic [1:0]             base_data;
    logic                   arr_rst_n;
    logic                   arr_en;
    logic [1:0]             arr_data;
    logic [LOG_LENGTH-1:0]  arr_sel;
    logic                   arr_vld;
    logic [SCORE_WIDTH-1:0] arr_result;
    logic                   res_valid;
    logic                   res_ready;
    logic [SCORE_WIDTH-1:0] res_score;
    logic                   res_err;
    logic                   busy;
`ifdef SW_CTRL_CYCLE_COUNT_EN
    logic [31:0]            res_cycles;
`endif

    modport slave (
        input  start_valid, start_qlen, start_tlen, abort, base_valid, base_data,
               arr_vld, arr_result, res_ready,
        output start_ready, base_ready, arr_rst_n, arr_en, arr_data, arr_sel,
`ifdef SW_CTRL_CYCLE_COUNT_EN
               res_cycles,
`endif
               res_valid, res_score, res_err, busy
    );

    modport master (
        output start_valid, start_qlen, start_tlen, abort, base_valid, base_data,
               arr_vld, arr_result, res_ready,
        input  start_ready, base_ready, arr_rst_n, arr_en, arr_data, arr_sel,
`ifdef SW_CTRL_CYCLE_COUNT_EN
               res_cycles,
`endif
               res_valid, res_score, res_err, busy
    );

endinterface

// File: rtl/sw_score_controller_down_counter.sv
// sw_down_counter: loadable down-counter with zero flag (load wins over decrement)
module sw_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);
    logic [W-1:0] cnt_d, cnt_q;

    // next count: load, else decrement when asked, else hold
    always_comb cnt_d = load ? load_val : dec ? cnt_q - W'(1) : cnt_q;

    // count register
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt  = cnt_q;
    assign zero = cnt_q == '0;

endmodule

// File: rtl/sw_score_controller.sv
// sw_score_controller: Smith-Waterman array job sequencer (clear, stream, drain, report)
// Optional SW_CTRL_CYCLE_COUNT_EN adds res_cycles, the accept-to-DONE cycle count.
module sw_score_controller
    import sw_pkg::*;
#(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 128,
    parameter int LOG_LENGTH  = $clog2(LENGTH + 1),
    parameter int TLEN_WIDTH  = 16,
    parameter int CLR_CYCLES  = 2,
    parameter int OUT_LAT     = 1,
    parameter int ZERO        = zero_bias(SCORE_WIDTH)
) (
    input logic clk,
    input logic rst,
    sw_score_controller_if.slave bus
);
    localparam int DW = $clog2(LENGTH + OUT_LAT + 2);
    localparam int CW = $clog2(CLR_CYCLES + 1);

    sw_state_e              state_d, state_q;
    logic                   rst_n_d, rst_n_q, en_d, en_q, valid_d, valid_q, err_d, err_q;
    logic [1:0]             data_d, data_q;
    logic [LOG_LENGTH-1:0]  sel_d, sel_q;
    logic [SCORE_WIDTH-1:0] score_d, score_q;
    logic [CW-1:0]          clr_d, clr_q;
    logic [TLEN_WIDTH-1:0]  base_cnt;
    logic [DW-1:0]          drain_cnt;
    logic                   base_zero, drain_zero, job_ok, accept, last;

    assign job_ok = bus.start_qlen != '0 && bus.start_qlen <= LOG_LENGTH'(LENGTH) && bus.start_tlen != '0;
    assign accept = state_q == STREAM && bus.base_valid;
    assign last   = accept && base_cnt == TLEN_WIDTH'(1);

    sw_down_counter #(.W(TLEN_WIDTH)) u_base (
        .clk(clk), .rst(rst),
        .load(state_q == IDLE && bus.start_valid),
        .dec(accept && !base_zero),
        .load_val(bus.start_tlen),
        .cnt(base_cnt), .zero(base_zero)
    );

    sw_down_counter #(.W(DW)) u_drain (
        .clk(clk), .rst(rst),
        .load(last),
        .dec(state_q == DRAIN && drain_cnt != '0),
        .load_val(DW'(sel_q) + DW'(OUT_LAT + 1)),
        .cnt(drain_cnt), .zero(drain_zero)
    );

    // job sequencing and next values of the registered outputs; abort overrides active states
    always_comb begin
        state_d = state_q;
        rst_n_d = rst_n_q;
        en_d    = 1'b0;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        score_d = score_q;
        err_d   = err_q;
        clr_d   = clr_q;
        case (state_q)
            IDLE: begin
                rst_n_d = 1'b1;
                if (bus.start_valid) begin
                    sel_d   = bus.start_qlen;
                    state_d = job_ok ? CLEAR : DONE;
                    rst_n_d = ~job_ok;
                    clr_d   = CW'(CLR_CYCLES - 1);
                    valid_d = ~job_ok;
                    err_d   = ~job_ok;
                    score_d = '0;
                end
            end
            CLEAR: begin
                state_d = clr_q == '0 ? STREAM : CLEAR;
                rst_n_d = clr_q == '0;
                clr_d   = clr_q == '0 ? clr_q : clr_q - CW'(1);
            end
            STREAM: begin
                en_d    = bus.base_valid;
                data_d  = bus.base_data;
                state_d = last ? DRAIN : STREAM;
            end
            DRAIN: if (drain_zero) begin
                state_d = DONE;
                valid_d = 1'b1;
                score_d = bus.arr_result - SCORE_WIDTH'(ZERO);
                err_d   = ~bus.arr_vld;
            end
            DONE: if (bus.res_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && (state_q == CLEAR || state_q == STREAM || state_q == DRAIN)) begin
            state_d = IDLE;
            en_d    = 1'b0;
            rst_n_d = 1'b0;
            valid_d = 1'b0;
            score_d = score_q;
            err_d   = err_q;
        end
    end

    // state and registered array/result outputs
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            rst_n_q <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            score_q <= '0;
            err_q   <= 1'b0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            rst_n_q <= rst_n_d;
            en_q    <= en_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            score_q <= score_d;
            err_q   <= err_d;
            clr_q   <= clr_d;
        end

    assign bus.start_ready = state_q == IDLE;
    assign bus.base_ready  = state_q == STREAM;
    assign bus.busy        = state_q != IDLE;
    assign bus.arr_rst_n   = rst_n_q;
    assign bus.arr_en      = en_q;
    assign bus.arr_data    = data_q;
    assign bus.arr_sel     = sel_q;
    assign bus.res_valid   = valid_q;
    assign bus.res_score   = score_q;
    assign bus.res_err     = err_q;

`ifdef SW_CTRL_CYCLE_COUNT_EN
    logic [31:0] cyc_d, cyc_q, cycles_d, cycles_q;

    // saturating count from job accept, captured on DONE entry (0 for rejected jobs)
    always_comb begin
        cyc_d    = (state_q == IDLE && bus.start_valid) ? 32'd1
                 : (cyc_q != '1 && (state_q == CLEAR || state_q == STREAM || state_q == DRAIN)) ? cyc_q + 32'd1
                 : cyc_q;
        cycles_d = (state_d == DONE && state_q != DONE) ? (state_q == IDLE ? '0 : cyc_q) : cycles_q;
    end

    // cycle counter and captured result
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cyc_q    <= '0;
            cycles_q <= '0;
        end else begin
            cyc_q    <= cyc_d;
            cycles_q <= cycles_d;
        end

    assign bus.res_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_sw_score_controller.sv
// tb_sw_score_controller: directed table-driven checks of the SW job sequencer
module tb_sw_score_controller;
    import sw_pkg::*;

    localparam int ZR = 2048;

    typedef struct {
        logic [7:0]  q;
        logic [15:0] t;
        logic [11:0] r;
        logic        v;
        logic        bub;
        logic        e;
        logic [11:0] s;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   en_cnt = 0;
    int   rl_cnt = 0;
    int   acc_cnt = 0;
    logic [1:0] codes [4];

    sw_score_controller_if bus ();
    sw_score_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // cycle tallies of array enable, array reset and accepted bases
    always @(negedge clk) begin
        if (bus.arr_en) en_cnt++;
        if (!bus.arr_rst_n) rl_cnt++;
        if (bus.base_valid && bus.base_ready) acc_cnt++;
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    function automatic bit is_legal(input vec_t v);
        return v.q != 0 && v.q <= 128 && v.t != 0;
    endfunction

    task automatic send(input vec_t v, input int nb, output bit to);
        int sent;
        int i;
        bit acc;
        sent = 0;
        i = 0;
        to = 0;
        bus.arr_result  = v.r;
        bus.arr_vld     = v.v;
        bus.start_valid = 1'b1;
        bus.start_qlen  = v.q;
        bus.start_tlen  = v.t;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        if (is_legal(v)) begin
            while (sent < nb && i < 200) begin
                bus.base_valid = v.bub ? (i % 2 == 0) : 1'b1;
                bus.base_data  = codes[sent % 4];
                acc = bus.base_valid && bus.base_ready;
                @(posedge clk); #1;
                if (acc) sent++;
                i++;
            end
            bus.base_valid = 1'b0;
            if (sent < nb) to = 1;
        end
    endtask

    task automatic run_job(input vec_t v, output int lat, output bit to);
        send(v, int'(v.t), to);
        lat = 0;
        while (!bus.res_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.res_valid) to = 1;
    endtask

    initial begin
        vec_t vecs [9];
        vec_t rd;
        int lat, e0, r0, a0, bad, exp_lat;
        bit to, legal;

        codes   = '{_G, _A, _C, _T};
        vecs[0] = '{8'd4,   16'd6, 12'(ZR + 9),   1'b1, 1'b0, 1'b0, 12'd9};
        vecs[1] = '{8'd4,   16'd6, 12'(ZR + 9),   1'b1, 1'b1, 1'b0, 12'd9};
        vecs[2] = '{8'd0,   16'd6, 12'(ZR + 9),   1'b1, 1'b0, 1'b1, 12'd0};
        vecs[3] = '{8'd129, 16'd6, 12'(ZR + 9),   1'b1, 1'b0, 1'b1, 12'd0};
        vecs[4] = '{8'd4,   16'd0, 12'(ZR + 9),   1'b1, 1'b0, 1'b1, 12'd0};
        vecs[5] = '{8'd1,   16'd1, 12'(ZR - 5),   1'b1, 1'b0, 1'b0, 12'd4091};
        vecs[6] = '{8'd128, 16'd3, 12'd0,         1'b1, 1'b0, 1'b0, 12'd2048};
        vecs[7] = '{8'd4,   16'd2, 12'(ZR + 3),   1'b0, 1'b0, 1'b1, 12'd3};
        vecs[8] = '{8'd2,   16'd5, 12'(ZR + 100), 1'b1, 1'b1, 1'b0, 12'd100};
        rd      = '{8'd128, 16'd1, 12'(ZR + 9),   1'b1, 1'b0, 1'b0, 12'd9};

        bus.start_valid = 1'b0;
        bus.start_qlen  = '0;
        bus.start_tlen  = '0;
        bus.abort       = 1'b0;
        bus.base_valid  = 1'b0;
        bus.base_data   = '0;
        bus.arr_vld     = 1'b0;
        bus.arr_result  = '0;
        bus.res_ready   = 1'b1;

        #2;
        chk("rst_arr_rst_n", bus.arr_rst_n, 0);
        chk("rst_arr_en", bus.arr_en, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_start_ready", bus.start_ready, 1);
        chk("rst_arr_sel", bus.arr_sel, 0);
        #20 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_arr_rst_n", bus.arr_rst_n, 1);

        for (int k = 0; k < 9; k++) begin
            e0 = en_cnt;
            r0 = rl_cnt;
            a0 = acc_cnt;
            legal = is_legal(vecs[k]);
            exp_lat = legal ? int'(vecs[k].q) + 3 : 0;
            run_job(vecs[k], lat, to);
            chk($sformatf("v%0d_timeout", k), to, 0);
            chk($sformatf("v%0d_res_err", k), bus.res_err, vecs[k].e);
            chk($sformatf("v%0d_res_score", k), bus.res_score, vecs[k].s);
            chk($sformatf("v%0d_en_cycles", k), en_cnt - e0, legal ? int'(vecs[k].t) : 0);
            chk($sformatf("v%0d_rstn_low", k), rl_cnt - r0, legal ? 2 : 0);
            chk($sformatf("v%0d_accepted", k), acc_cnt - a0, legal ? int'(vecs[k].t) : 0);
            chk($sformatf("v%0d_latency", k), lat, exp_lat);
            @(posedge clk); #1;
            chk($sformatf("v%0d_res_valid_clr", k), bus.res_valid, 0);
            chk($sformatf("v%0d_start_ready", k), bus.start_ready, 1);
        end

        bus.res_ready = 1'b0;
        run_job(vecs[0], lat, to);
        chk("bp_timeout", to, 0);
        chk("bp_score", bus.res_score, 9);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bus.res_valid || bus.res_score != 12'd9 || bus.res_err || bus.start_ready || !bus.busy) bad++;
        end
        chk("bp_hold_stable", bad, 0);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", bus.res_valid, 0);
        chk("bp_release_start_ready", bus.start_ready, 1);

        send(vecs[0], 3, to);
        chk("ab_stream_timeout", to, 0);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("ab_busy", bus.busy, 0);
        chk("ab_arr_rst_n_low", bus.arr_rst_n, 0);
        chk("ab_arr_en", bus.arr_en, 0);
        @(posedge clk); #1;
        chk("ab_arr_rst_n_release", bus.arr_rst_n, 1);
        bad = 0;
        repeat (8) begin
            if (bus.res_valid) bad++;
            @(posedge clk); #1;
        end
        chk("ab_no_result", bad, 0);
        e0 = en_cnt;
        run_job(vecs[0], lat, to);
        chk("ab_next_timeout", to, 0);
        chk("ab_next_score", bus.res_score, 9);
        chk("ab_next_err", bus.res_err, 0);
        chk("ab_next_en_cycles", en_cnt - e0, 6);
        @(posedge clk); #1;

        send(rd, 1, to);
        chk("rd_stream_timeout", to, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rd_pre_busy", bus.busy, 1);
        chk("rd_pre_sel", bus.arr_sel, 128);
        chk("rd_pre_data", bus.arr_data, _G);
        #2 rst = 1'b1;
        #1;
        chk("rd_busy", bus.busy, 0);
        chk("rd_start_ready", bus.start_ready, 1);
        chk("rd_arr_rst_n", bus.arr_rst_n, 0);
        chk("rd_arr_en", bus.arr_en, 0);
        chk("rd_arr_sel", bus.arr_sel, 0);
        chk("rd_arr_data", bus.arr_data, 0);
        chk("rd_res_valid", bus.res_valid, 0);
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_job(vecs[5], lat, to);
        chk("post_rst_timeout", to, 0);
        chk("post_rst_score", bus.res_score, 4091);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sw_score_controller.md
Name: sw_score_controller

Overview:
- Job sequencer for the Smith-Waterman systolic scoring array. Per job:
  - accepts query length and target length from the host;
  - clears the array;
  - streams target bases into the array with valid/ready backpressure;
  - waits the systolic drain latency;
  - captures the selected PE high score, removes the bias, and presents it on a result handshake.
- Sits between the host/DMA base stream and the scoring array; owns the array's enable, reset and output-select lines.

Parameters:
- SCORE_WIDTH, 12, score width in bits; must match the array.
- LENGTH, 128, number of PEs in the array.
- LOG_LENGTH, floor(log2(LENGTH))+1 (8 for 128), width of query length / output select; holds 1..LENGTH.
- TLEN_WIDTH, 16, target length counter width.
- CLR_CYCLES, 2, cycles the array reset is held per job (>=1).
- OUT_LAT, 1, extra cycles after drain before sampling the array (array output-select register).
- ZERO, 2**(SCORE_WIDTH-1), bias value of the array's zero score.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  job request valid.
- start_ready  out  1  controller can accept a job.
- start_qlen  in  LOG_LENGTH  query length.
- start_tlen  in  TLEN_WIDTH  target length in bases.
- abort  in  1  cancel the current job.
- base_valid  in  1  target base valid.
- base_ready  out  1  base accepted this cycle.
- base_data  in  2  target base (T=00, C=01, A=10, G=11).
- arr_rst_n  out  1  array synchronous active-low reset.
- arr_en  out  1  array en_in.
- arr_data  out  2  array data_in.
- arr_sel  out  LOG_LENGTH  array output_select.
- arr_vld  in  1  array vld.
- arr_result  in  SCORE_WIDTH  array biased result.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_score  out  SCORE_WIDTH  unbiased score.
- res_err  out  1  job error flag; qualified by res_valid.
- busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered except start_ready, base_ready and busy, which decode the state.
- Reset values:
  - state=IDLE, arr_rst_n=0, arr_en=0, arr_data=0, arr_sel=0;
  - res_valid=0, res_score=0, res_err=0;
  - all counters 0.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - start_ready=1; arr_rst_n=1.
  - On start_valid, latch qlen into arr_sel and tlen into the base counter.
  - If qlen==0, qlen>LENGTH or tlen==0: go to DONE with res_err=1 and res_score=0.
  - Otherwise go to CLEAR.
- CLEAR: arr_rst_n=0 for exactly CLR_CYCLES cycles, then STREAM. arr_sel is held stable from the job latch to DONE exit.
- STREAM:
  - base_ready=1. Each cycle: arr_en<=base_valid, arr_data<=base_data.
  - Bubbles (base_valid=0) are legal and propagate as disabled array cycles.
  - The base counter decrements on each accepted base.
  - When the accept takes the counter from 1 to 0, go to DRAIN in the next cycle.
  - Extra bases are never accepted.
- DRAIN:
  - arr_en=0, base_ready=0.
  - Down-counter loaded with qlen+OUT_LAT+1 on entry.
  - At count 0: sample arr_vld and arr_result, set res_score<=arr_result-ZERO (modulo 2**SCORE_WIDTH), set res_err<=~arr_vld, then go to DONE.
- DONE:
  - res_valid=1; res_score and res_err are held stable until res_ready.
  - On res_valid&res_ready: res_valid<=0, state<=IDLE in the same edge.
- abort:
  - Highest priority in CLEAR, STREAM and DRAIN: go to IDLE next cycle, arr_en<=0, arr_rst_n<=0 for one cycle. No result is produced.
  - Ignored in IDLE and DONE.
- A start_valid held during busy is not accepted; start_ready=0.
- Async rst mid-job: immediate return to reset values; any partial job is discarded.

Optional Feature:
- Macro: SW_CTRL_CYCLE_COUNT_EN.
- Defined:
  - Adds output res_cycles [31:0], holding the cycle count from job accept to DONE entry; saturates at 2**32-1.
  - Captured with res_score; reset value 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sw_pkg holds:
  - the FSM state enum;
  - nucleotide codes _A/_G/_T/_C;
  - the ZERO bias function of SCORE_WIDTH.
- One natural sub-module, sw_down_counter (load, decrement, zero flag). It is instantiated twice: base count and drain count.

Test Plan:
- Basic job: qlen=4, tlen=6, 6 back-to-back bases, model array returns arr_result=ZERO+9 with vld=1 → arr_en high exactly 6 cycles; arr_rst_n low 2 cycles; sampling 6 cycles after the last base; res_score=9, res_err=0.
- Bubbles: the same job with base_valid toggling 1,0,1,0 → arr_en matches the accepted pattern; exactly 6 bases accepted; result unchanged.
- Illegal lengths: start with qlen=0, then qlen=129, then tlen=0 → no CLEAR and arr_en never high; res_valid with res_err=1 and res_score=0 each time.
- Backpressure: res_ready held 0 for 10 cycles → res_valid and res_score stable; start_ready=0 throughout.
- Abort mid-STREAM after 3 of 6 bases → IDLE next cycle; arr_rst_n low 1 cycle; no res_valid; a following job completes normally.
- Async rst asserted in DRAIN → all outputs reach reset values without a clock edge; busy=0.
